// File: rtl/rr_mux_arb_if.sv
// rtl/rr_mux_arb_if.sv - handshake bundle between producers, arbiter and consumer
interface rr_mux_arb_if #(
    parameter int  WIDTH  = 16,
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-input registered mux with round-robin or fixed-select arbitration
module rr_mux_arb #(
    parameter int  WIDTH  = 16,
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_arb_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   src_q;

    logic               load_en;
    logic [NUM_IN-1:0]  eligible;
    logic [NUM_IN-1:0]  grant;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_any;
    logic               xfer;
    logic [SEL_W-1:0]   next_ptr;
    logic [WIDTH-1:0]   grant_word;

    // An out-of-range sel never matches any channel index, so nothing is granted.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = bus.in_valid[i] & (~bus.mode | (bus.sel == SEL_W'(i)));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!grant_any && eligible[idx]) begin
                grant_any      = 1'b1;
                grant_idx      = SEL_W'(idx);
                grant[idx]     = 1'b1;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) grant_word = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load_en  = (state == EMPTY) | bus.out_ready;
    assign xfer     = grant_any & load_en & ~rst;
    assign next_ptr = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

    assign bus.in_ready  = grant & {NUM_IN{load_en & ~rst}};
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            data_q <= '0;
            src_q  <= '0;
            ptr    <= '0;
        end else if (xfer) begin
            state  <= FULL;
            data_q <= grant_word;
            src_q  <= grant_idx;
            if (!bus.mode) ptr <= next_ptr;
        end else if (bus.out_ready) begin
            state  <= EMPTY;
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - self-checking bench for rr_mux_arb (8-input and 5-input builds)
module tb_rr_mux_arb;
    logic clk = 1'b0;
    logic rst;
    logic chk_en;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rr_mux_arb_if #(.WIDTH(16), .NUM_IN(8)) bus8 ();
    rr_mux_arb_if #(.WIDTH(16), .NUM_IN(5)) bus5 ();

    rr_mux_arb #(.WIDTH(16), .NUM_IN(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rr_mux_arb #(.WIDTH(16), .NUM_IN(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the 8-input build: held word plus rotating start index.
    int          m_ptr;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_src;

    function automatic int pick();
        int c;
        if (rst) return -1;
        if (m_valid && !bus8.out_ready) return -1;
        for (int k = 0; k < 8; k++) begin
            c = (m_ptr + k) % 8;
            if (bus8.in_valid[c] && (!bus8.mode || int'(bus8.sel) == c)) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 16'h0;
            m_src   = 0;
            m_ptr   = 0;
        end else begin
            g = pick();
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus8.in_data[g*16 +: 16];
                m_src   = g;
                if (!bus8.mode) m_ptr = (g + 1) % 8;
            end else if (m_valid && bus8.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int         g;
        logic [7:0] er;
        if (chk_en) begin
            g  = pick();
            er = (g >= 0) ? 8'(1 << g) : 8'h00;
            chk("model_in_ready", bus8.in_ready, er);
            chk("model_out_valid", bus8.out_valid, m_valid);
            chk("model_out_data", bus8.out_data, m_data);
            chk("model_out_src", bus8.out_src, m_src);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        chk_en = 1'b0;
        for (int i = 0; i < 8; i++) bus8.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
        bus8.in_valid  = 8'hFF;
        bus8.mode      = 1'b0;
        bus8.sel       = 3'd0;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) bus5.in_data[i*16 +: 16] = 16'h5000 + 16'(i);
        bus5.in_valid  = 5'h1F;
        bus5.mode      = 1'b1;
        bus5.sel       = 3'd6;
        bus5.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", bus8.out_valid, 0);
        chk("rst_out_data", bus8.out_data, 0);
        chk("rst_out_src", bus8.out_src, 0);
        chk("rst_in_ready", bus8.in_ready, 0);

        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rr_first_ready", bus8.in_ready, 8'h01);
        chk("rr_first_latency", bus8.out_valid, 0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_seq_valid", bus8.out_valid, 1);
            chk("rr_seq_src", bus8.out_src, k % 8);
            chk("rr_seq_data", bus8.out_data, 16'h1000 + 16'(k % 8));
            chk("n5_badsel_ready", bus5.in_ready, 0);
            chk("n5_badsel_valid", bus5.out_valid, 0);
        end

        step();
        bus8.in_valid = 8'h04;
        @(negedge clk);
        chk("wrap_ready_ch2", bus8.in_ready, 8'h04);
        step();
        bus8.in_valid = 8'h84;
        @(negedge clk);
        chk("wrap_src_ch2", bus8.out_src, 2);
        chk("wrap_ready_ch7", bus8.in_ready, 8'h80);
        step();
        @(negedge clk);
        chk("wrap_src_ch7", bus8.out_src, 7);
        chk("wrap_ready_back2", bus8.in_ready, 8'h04);
        step();

        bus8.in_valid = 8'h08;
        bus8.in_data[3*16 +: 16] = 16'hBEEF;
        @(negedge clk);
        chk("wrap_src_2_again", bus8.out_src, 2);
        step();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            chk("stall_data", bus8.out_data, 16'hBEEF);
            chk("stall_ready", bus8.in_ready, 0);
            chk("stall_valid", bus8.out_valid, 1);
        end
        step();
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready", bus8.in_ready, 8'h10);
        step();

        bus8.mode = 1'b1;
        bus8.sel  = 3'd5;
        @(negedge clk);
        chk("unstall_src", bus8.out_src, 4);
        chk("unstall_data", bus8.out_data, 16'h1004);
        chk("fixed_ready", bus8.in_ready, 8'h20);
        repeat (3) begin
            @(negedge clk);
            chk("fixed_src", bus8.out_src, 5);
        end
        step();
        bus8.in_valid = 8'hDF;
        @(negedge clk);
        chk("fixed_novalid_ready", bus8.in_ready, 0);
        @(negedge clk);
        chk("fixed_drain_valid", bus8.out_valid, 0);
        step();
        bus8.mode     = 1'b0;
        bus8.in_valid = 8'hFF;
        @(negedge clk);
        chk("resume_ptr_ready", bus8.in_ready, 8'h20);
        @(negedge clk);
        chk("resume_src", bus8.out_src, 5);
        chk("resume_valid", bus8.out_valid, 1);

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus8.out_valid, 0);
        chk("async_rst_data", bus8.out_data, 0);
        chk("async_rst_src", bus8.out_src, 0);
        step();
        rst           = 1'b0;
        bus8.in_valid = 8'h30;
        bus5.sel      = 3'd4;
        @(negedge clk);
        chk("post_rst_ready", bus8.in_ready, 8'h10);
        chk("n5_sel4_ready", bus5.in_ready, 5'h10);
        @(negedge clk);
        chk("post_rst_src", bus8.out_src, 4);
        chk("post_rst_data", bus8.out_data, 16'h1004);
        chk("n5_sel4_src", bus5.out_src, 4);
        chk("n5_sel4_data", bus5.out_data, 16'h5004);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
